// File: rtl/mdio_cmd_ctrl.sv
// mdio_cmd_ctrl: command front end for the MDIO frame engine.
// Buffers read/write commands in a small FIFO, then issues them one at a time
// on the engine's tvalid/done handshake. The frame fields stay stable for the
// whole frame. Exactly one response is returned per accepted command.
// Optional feature macro: MDIO_TIMEOUT_EN adds a done-handshake timeout that
// completes a stalled frame with rsp_err=1.
module mdio_cmd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TVALID_HOLD    = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        opr_tvalid,
    output logic [1:0]  opr_op_code,
    output logic [4:0]  opr_phy_addr,
    output logic [4:0]  opr_reg_addr,
    output logic [15:0] opr_senddata,
    input  logic [15:0] opr_recvdata,
    input  logic        opr_done
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 28;
    localparam int MAX_HG  = (TVALID_HOLD > GAP_CYCLES) ? TVALID_HOLD : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TVALID_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef MDIO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RESP,
        S_GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               set_err;
    logic               capture;

    logic [15:0]        rdata_q;
    logic               err_q;

    assign cmd_ready  = (fifo_cnt != FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = cmd_valid & cmd_ready;
    assign head       = fifo_mem[rd_ptr];

    // FIFO storage: payload words are not reset, only pointers and count are
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_phy, cmd_reg, cmd_wdata};
        end
    end

    // FIFO pointers wrap naturally; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        set_err    = 1'b0;
        capture    = 1'b0;
        opr_tvalid = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                // the engine survives our reset, so never start while it is mid-frame
                if (!fifo_empty && opr_done) begin
                    pop       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_clr = 1'b1;
                if (opr_op_code == OP_READ || opr_op_code == OP_WRITE) begin
                    state_nxt = S_ISSUE;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_ISSUE: begin
                opr_tvalid = 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_WAIT_LOW;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                if (!opr_done) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_WAIT_HIGH;
                end
`ifdef MDIO_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
            S_WAIT_HIGH: begin
                if (opr_done) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
`ifdef MDIO_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // shared cycle counter for tvalid hold, inter-frame gap and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // frame fields load only on pop and then hold, since the engine samples them live
    always_ff @(posedge clk) begin
        if (rst) begin
            opr_op_code  <= '0;
            opr_phy_addr <= '0;
            opr_reg_addr <= '0;
            opr_senddata <= '0;
        end else if (pop) begin
            opr_op_code  <= head[27:26];
            opr_phy_addr <= head[25:21];
            opr_reg_addr <= head[20:16];
            opr_senddata <= head[15:0];
        end
    end

    // response payload: read data captured as done rises, forced to 0 on error
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (pop) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (set_err) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (capture) begin
            rdata_q <= (opr_op_code == OP_READ) ? opr_recvdata : 16'h0000;
            err_q   <= 1'b0;
        end
    end

    assign rsp_err   = err_q & rsp_valid;
    assign rsp_rdata = rsp_valid ? rdata_q : 16'h0000;
    assign busy      = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_mdio_cmd_ctrl.sv
// Testbench for mdio_cmd_ctrl: behavioural MDIO engine plus a command-order
// scoreboard. Build with +define+MDIO_TIMEOUT_EN to exercise the timeout path.
module tb_mdio_cmd_ctrl;

    localparam int FIFO_DEPTH     = 4;
    localparam int TVALID_HOLD    = 2;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        opr_tvalid;
    logic [1:0]  opr_op_code;
    logic [4:0]  opr_phy_addr;
    logic [4:0]  opr_reg_addr;
    logic [15:0] opr_senddata;
    logic [15:0] opr_recvdata;
    logic        opr_done;

    mdio_cmd_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TVALID_HOLD   (TVALID_HOLD),
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_phy     (cmd_phy),
        .cmd_reg     (cmd_reg),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .opr_tvalid  (opr_tvalid),
        .opr_op_code (opr_op_code),
        .opr_phy_addr(opr_phy_addr),
        .opr_reg_addr(opr_reg_addr),
        .opr_senddata(opr_senddata),
        .opr_recvdata(opr_recvdata),
        .opr_done    (opr_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
    } cmd_t;

    cmd_t rsp_q[$];
    cmd_t iss_q[$];

    // register contents of the modelled PHYs
    function automatic logic [15:0] phy_reg_value(input logic [4:0] phy, input logic [4:0] rg);
        if (phy == 5'h03 && rg == 5'h02) return 16'h0141;
        return {phy, rg, 6'h2A} ^ 16'h5A00;
    endfunction

    // engine model state
    bit          eng_busy    = 0;
    bit          eng_stuck   = 0;
    bit          eng_aborted = 0;
    bit          end_valid   = 0;
    int          eng_cnt     = 0;
    int          eng_len     = 0;
    int          eng_fixed_len = 0;
    int          early_issue = 0;
    int          n_rises     = 0;
    int          n_rsp       = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned last_end_cyc  = 0;
    int unsigned last_rsp_cyc  = 0;

    // behavioural MDIO engine: frame starts on tvalid rise, done low for eng_len cycles
    initial begin
        logic        tv_prev;
        logic        unstable;
        logic [27:0] cur;
        logic [27:0] eng_fields;
        int          hi_len;
        cmd_t        e;
        opr_done     = 1'b1;
        opr_recvdata = 16'h0000;
        tv_prev      = 1'b0;
        unstable     = 1'b0;
        eng_fields   = '0;
        hi_len       = 0;
        forever begin
            @(posedge clk);
            #1;
            cur = {opr_op_code, opr_phy_addr, opr_reg_addr, opr_senddata};
            if (opr_tvalid === 1'b1) begin
                hi_len++;
            end else if (hi_len != 0) begin
                check("tvalid_hold", hi_len, TVALID_HOLD);
                hi_len = 0;
            end
            if (opr_tvalid === 1'b1 && !tv_prev) begin
                last_rise_cyc = cyc;
                n_rises++;
                if (eng_busy) early_issue++;
                if (end_valid) check("frame_gap", 32'(cyc - last_end_cyc > GAP_CYCLES), 1);
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", opr_tvalid, 0);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_fields", {opr_op_code, opr_phy_addr, opr_reg_addr}, {e.op, e.phy, e.rg});
                    if (e.op == 2'b01) check("issue_wdata", opr_senddata, e.wdata);
                end
                if (!eng_busy && !eng_stuck) begin
                    eng_busy     = 1;
                    eng_cnt      = 0;
                    eng_aborted  = 0;
                    unstable     = 1'b0;
                    eng_fields   = cur;
                    eng_len      = (eng_fixed_len != 0) ? eng_fixed_len : int'($urandom_range(4, 12));
                    opr_done     = 1'b0;
                    opr_recvdata = 16'($urandom);
                end
            end else if (eng_busy) begin
                eng_cnt++;
                if (cur != eng_fields) unstable = 1'b1;
                if (eng_cnt >= eng_len) begin
                    opr_done     = 1'b1;
                    opr_recvdata = phy_reg_value(eng_fields[25:21], eng_fields[20:16]);
                    if (!eng_aborted) check("fields_stable", unstable, 0);
                    eng_busy     = 0;
                    last_end_cyc = cyc;
                    end_valid    = !eng_aborted;
                end
            end
            tv_prev = (opr_tvalid === 1'b1);
        end
    end

    // response monitor: every pulse must match the oldest outstanding command
    initial begin
        logic rsp_prev;
        cmd_t e;
        rsp_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                last_rsp_cyc = cyc;
                if (rsp_prev) check("rsp_single_cycle", rsp_prev, 0);
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            rsp_prev = (rsp_valid === 1'b1);
        end
    end

    task automatic push(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wdata, output int unsigned acc);
        cmd_t e;
        int   t;
        bit   valid_op;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_phy   = phy;
        cmd_reg   = rg;
        cmd_wdata = wdata;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        acc = 0;
        if (!cmd_ready) begin
            check("push_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        valid_op = (op == 2'b01) || (op == 2'b10);
        e.op    = op;
        e.phy   = phy;
        e.rg    = rg;
        e.wdata = wdata;
        e.err   = !valid_op || eng_stuck;
        e.rdata = (!e.err && op == 2'b10) ? phy_reg_value(phy, rg) : 16'h0000;
        rsp_q.push_back(e);
        if (valid_op) iss_q.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || busy) && t < limit) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", rsp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {cmd_ready, rsp_valid, rsp_err, busy, opr_tvalid, opr_op_code, opr_phy_addr, opr_reg_addr},
              17'h10000);
        check({tag, "_data"}, {rsp_rdata, opr_senddata}, 32'h0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_q.delete();
        iss_q.delete();
        end_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        int          r0;
        int          t;
        logic [1:0]  ops_tbl [6];
        logic [1:0]  op;
        ops_tbl = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_phy   = '0;
        cmd_reg   = '0;
        cmd_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // write with latency check from an idle controller
        r0 = n_rsp;
        push(2'b01, 5'h01, 5'h00, 16'h8000, acc);
        wait_drain(500);
        check("write_latency", last_rise_cyc - acc, 2);
        check("write_rsp_count", n_rsp - r0, 1);

        // read returns engine data
        r0 = n_rsp;
        push(2'b10, 5'h03, 5'h02, 16'h1234, acc);
        wait_drain(500);
        check("read_rsp_count", n_rsp - r0, 1);
        check("read_latency", last_rise_cyc - acc, 2);

        // queueing behind a long frame: FIFO fills at FIFO_DEPTH
        r0 = n_rsp;
        eng_fixed_len = 60;
        push(2'b10, 5'h04, 5'h01, 16'h0000, acc);
        t = 0;
        while (opr_done && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("engine_started", opr_done, 0);
        for (int i = 0; i < 4; i++) begin
            push(2'($urandom_range(1, 2)), 5'($urandom), 5'($urandom), 16'($urandom), acc);
        end
        check("ready_full", cmd_ready, 0);
        push(2'b01, 5'h1F, 5'h1E, 16'hBEEF, acc);
        eng_fixed_len = 0;
        wait_drain(3000);
        check("queue_rsp_count", n_rsp - r0, 6);

        // invalid ops never reach the engine
        r0 = n_rises;
        push(2'b00, 5'h02, 5'h03, 16'h5555, acc);
        push(2'b11, 5'h02, 5'h03, 16'hAAAA, acc);
        wait_drain(500);
        check("invalid_no_issue", n_rises - r0, 0);
        push(2'b10, 5'h03, 5'h02, 16'h0000, acc);
        wait_drain(500);
        check("read_after_invalid", n_rises - r0, 1);

        // randomized mix with random gaps
        r0 = n_rsp;
        for (int i = 0; i < 24; i++) begin
            op = ops_tbl[$urandom_range(0, 5)];
            push(op, 5'($urandom), 5'($urandom), 16'($urandom), acc);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain(5000);
        check("random_rsp_count", n_rsp - r0, 24);

        // reset in the middle of a frame with commands queued
        eng_fixed_len = 150;
        push(2'b10, 5'h05, 5'h06, 16'h0000, acc);
        push(2'b01, 5'h05, 5'h07, 16'h1111, acc);
        push(2'b10, 5'h05, 5'h08, 16'h0000, acc);
        t = 0;
        while (!(eng_busy && eng_cnt >= 100) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reset_engine_mid_frame", eng_busy, 1);
        eng_aborted = 1;
        r0 = n_rsp;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_frame");
        rst = 1'b0;
        rsp_q.delete();
        iss_q.delete();
        end_valid = 0;
        eng_fixed_len = 0;
        push(2'b10, 5'h03, 5'h02, 16'h0000, acc);
        wait_drain(1000);
        check("reset_waits_done", early_issue, 0);
        check("post_reset_rsp_count", n_rsp - r0, 1);

        // engine never starts a frame
        eng_stuck = 1;
        r0 = n_rsp;
        push(2'b10, 5'h07, 5'h03, 16'h0000, acc);
`ifdef MDIO_TIMEOUT_EN
        wait_drain(1000);
        check("timeout_rsp_count", n_rsp - r0, 1);
        check("timeout_latency", last_rsp_cyc - last_rise_cyc, TVALID_HOLD + TIMEOUT_CYCLES);
`else
        repeat (400) begin
            @(posedge clk);
            #1;
        end
        check("stuck_busy", busy, 1);
        check("stuck_no_rsp", n_rsp - r0, 0);
        apply_reset();
        check_reset_outputs("stuck_recover");
`endif
        eng_stuck = 0;
        check("early_issue_total", early_issue, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
